cv32e40p_ft_breakage_monitor: RTL

//  Per-replica error-rate monitor behind the TMR voters of the FT aligner and FT compressed decoder.

---
 rtl/cv32e40p_ft_breakage_monitor.sv | 108 ++++++++++
 1 files changed

// File: rtl/cv32e40p_ft_breakage_monitor.sv
// Per-replica leaky-bucket error monitor behind a TMR voter.
// Each replica runs OK/SUSPECT/BROKEN; BROKEN is sticky until rst or clear.
module cv32e40p_ft_breakage_monitor #(
    parameter int unsigned N_REPLICA          = 3,
    parameter int unsigned INCREMENT          = 1,
    parameter int unsigned DECREMENT          = 1,
    parameter int unsigned BREAKING_THRESHOLD = 3,
    parameter int unsigned COUNT_BIT          = 8,
    parameter int unsigned INC_DEC_BIT        = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_i,
    input  logic                           valid_i,
    input  logic [N_REPLICA-1:0]           err_i,
    output logic [N_REPLICA-1:0]           broken_o,
    output logic                           degraded_o,
    output logic                           fatal_o,
    output logic [N_REPLICA*COUNT_BIT-1:0] cnt_o
);

    localparam int unsigned CMAX = (1 << COUNT_BIT) - 1;
    localparam int unsigned CW   = COUNT_BIT + 1;
    localparam int unsigned NB_W = $clog2(N_REPLICA + 1);

    localparam logic [COUNT_BIT:0]   INC_X  = CW'(INCREMENT);
    localparam logic [COUNT_BIT:0]   CMAX_X = CW'(CMAX);
    localparam logic [COUNT_BIT-1:0] CMAX_C = COUNT_BIT'(CMAX);
    localparam logic [COUNT_BIT-1:0] DEC_C  = COUNT_BIT'(DECREMENT);
    localparam logic [COUNT_BIT-1:0] TH_C   = COUNT_BIT'(BREAKING_THRESHOLD);

    if (N_REPLICA != 3) begin : g_bad_replica
        $error("N_REPLICA must be 3");
    end
    if (INCREMENT >= (1 << INC_DEC_BIT) || DECREMENT >= (1 << INC_DEC_BIT)) begin : g_bad_incdec
        $error("INCREMENT/DECREMENT exceed INC_DEC_BIT width");
    end
    if (BREAKING_THRESHOLD > CMAX) begin : g_bad_threshold
        $error("BREAKING_THRESHOLD above counter saturation value");
    end

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_BROKEN  = 2'd2
    } state_e;

    state_e               state_q [N_REPLICA];
    state_e               state_d [N_REPLICA];
    logic [COUNT_BIT-1:0] cnt_q   [N_REPLICA];
    logic [COUNT_BIT-1:0] cnt_d   [N_REPLICA];
    logic [COUNT_BIT:0]   sum;
    logic [NB_W-1:0]      n_broken;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            for (int k = 0; k < N_REPLICA; k++) begin
                state_q[k] <= ST_OK;
                cnt_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < N_REPLICA; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    // Arithmetic is widened by one bit so the increment saturates instead of wrapping.
    always_comb begin
        sum = '0;
        for (int k = 0; k < N_REPLICA; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            if (valid_i && state_q[k] != ST_BROKEN) begin
                if (err_i[k]) begin
                    sum      = {1'b0, cnt_q[k]} + INC_X;
                    cnt_d[k] = (sum > CMAX_X) ? CMAX_C : sum[COUNT_BIT-1:0];
                end else begin
                    cnt_d[k] = (cnt_q[k] > DEC_C) ? cnt_q[k] - DEC_C : '0;
                end
                if (cnt_d[k] >= TH_C) begin
                    state_d[k] = ST_BROKEN;
                end else if (cnt_d[k] == '0) begin
                    state_d[k] = ST_OK;
                end else begin
                    state_d[k] = ST_SUSPECT;
                end
            end
        end
    end

    always_comb begin
        broken_o = '0;
        cnt_o    = '0;
        n_broken = '0;
        for (int k = 0; k < N_REPLICA; k++) begin
            broken_o[k]                      = (state_q[k] == ST_BROKEN);
            cnt_o[k*COUNT_BIT +: COUNT_BIT]  = cnt_q[k];
            if (state_q[k] == ST_BROKEN) begin
                n_broken = n_broken + 1'b1;
            end
        end
        degraded_o = (n_broken == NB_W'(1));
        fatal_o    = (n_broken >= NB_W'(2));
    end

endmodule
